// File: rtl/csr_timer_pkg.sv
// rtl/csr_timer_pkg.sv - CSR addresses, field positions and write-merge helper for the timer block
package csr_timer_pkg;

  // CSR addresses owned by the timer block
  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  // Field positions
  localparam int CSR_TCFG_EN        = 0;
  localparam int CSR_TCFG_PERIOD    = 1;
  localparam int CSR_TCFG_INITV_LSB = 2;
  localparam int CSR_TICLR_CLR      = 0;

  // Masked write: bits with wmask=1 take the new value, the rest keep the old one
  function automatic logic [31:0] csr_merge(input logic [31:0] old_value,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_value);
  endfunction

endpackage

// File: rtl/stable_counter.sv
// rtl/stable_counter.sv - free-running 64-bit stable counter
module stable_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Increment every cycle; natural wrap from all-ones to zero
  always_comb begin
    value_d = value_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Single register so both halves are always read coherently
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - timer CSRs (TID/TCFG/TVAL/TICLR), timer interrupt and stable counter
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic        timer_csr_hit,
  output logic [31:0] timer_csr_rvalue,
  output logic        timer_int,
  output logic [63:0] cnt_value,
  output logic [31:0] cnt_id
);

  logic [31:0]        tid_q, tid_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               timer_int_q, timer_int_d;

  logic               wr_tid, wr_tcfg, wr_ticlr;
  logic [31:0]        tcfg_merged;
  logic [TIMER_W-1:0] tcfg_new;
  logic [TIMER_W-1:0] reload_old, reload_new;
  logic               tcfg_en, tcfg_periodic;
  logic               tval_zero, tval_ones;

  // Decode write strobes and prepare the merged TCFG value and reload values
  always_comb begin
    wr_tid        = csr_we && (csr_num == CSR_TID);
    wr_tcfg       = csr_we && (csr_num == CSR_TCFG);
    wr_ticlr      = csr_we && (csr_num == CSR_TICLR) &&
                    csr_wmask[CSR_TICLR_CLR] && csr_wvalue[CSR_TICLR_CLR];
    tcfg_merged   = csr_merge(32'(tcfg_q), csr_wmask, csr_wvalue);
    tcfg_new      = tcfg_merged[TIMER_W-1:0];
    tcfg_en       = tcfg_q[CSR_TCFG_EN];
    tcfg_periodic = tcfg_q[CSR_TCFG_PERIOD];
    reload_old    = {tcfg_q[TIMER_W-1:CSR_TCFG_INITV_LSB], 2'b00};
    reload_new    = {tcfg_new[TIMER_W-1:CSR_TCFG_INITV_LSB], 2'b00};
    tval_zero     = (tval_q == '0);
    tval_ones     = (tval_q == '1);
  end

  // Next-state for TID, TCFG, TVAL and the interrupt flag
  always_comb begin
    tid_d       = wr_tid  ? csr_merge(tid_q, csr_wmask, csr_wvalue) : tid_q;
    tcfg_d      = wr_tcfg ? tcfg_new : tcfg_q;
    tval_d      = tval_q;
    timer_int_d = timer_int_q;

    // A TCFG write either starts a fresh countdown or, with En cleared, freezes TVAL
    if (wr_tcfg) begin
      if (tcfg_new[CSR_TCFG_EN]) begin
        tval_d = reload_new;
      end
    end else if (tcfg_en && !tval_ones) begin
      if (tval_zero && tcfg_periodic) begin
        tval_d = reload_old;
      end else begin
        // One-shot expiry falls through to 0 - 1 = all-ones and then stops
        tval_d = tval_q - {{(TIMER_W-1){1'b0}}, 1'b1};
      end
    end

    // Clear first so a coincident expiry overrides it
    if (wr_ticlr) begin
      timer_int_d = 1'b0;
    end
    if (tcfg_en && tval_zero) begin
      timer_int_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tid_q       <= '0;
      tcfg_q      <= '0;
      tval_q      <= '1;
      timer_int_q <= 1'b0;
    end else begin
      tid_q       <= tid_d;
      tcfg_q      <= tcfg_d;
      tval_q      <= tval_d;
      timer_int_q <= timer_int_d;
    end
  end

  // Combinational read mux from current state; TICLR has no storage and reads 0
  always_comb begin
    timer_csr_hit    = 1'b0;
    timer_csr_rvalue = 32'h0;
    case (csr_num)
      CSR_TID: begin
        timer_csr_hit    = 1'b1;
        timer_csr_rvalue = tid_q;
      end
      CSR_TCFG: begin
        timer_csr_hit    = 1'b1;
        timer_csr_rvalue = 32'(tcfg_q);
      end
      CSR_TVAL: begin
        timer_csr_hit    = 1'b1;
        timer_csr_rvalue = 32'(tval_q);
      end
      CSR_TICLR: begin
        timer_csr_hit    = 1'b1;
      end
      default: begin
        timer_csr_hit    = 1'b0;
      end
    endcase
  end

  stable_counter #(.W(64)) u_stable_counter (
    .clk   (clk),
    .reset (reset),
    .value (cnt_value)
  );

  assign timer_int = timer_int_q;
  assign cnt_id    = tid_q;

endmodule

// File: tb/tb_csr_timer.sv
// tb/tb_csr_timer.sv - self-checking bench for csr_timer with a behavioural reference model
module tb_csr_timer;

  localparam logic [13:0] A_TID   = 14'h40;
  localparam logic [13:0] A_TCFG  = 14'h41;
  localparam logic [13:0] A_TVAL  = 14'h42;
  localparam logic [13:0] A_TICLR = 14'h44;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_we = 1'b0;
  logic [13:0] csr_num = 14'h0;
  logic [31:0] csr_wmask = 32'h0;
  logic [31:0] csr_wvalue = 32'h0;
  logic        timer_csr_hit;
  logic [31:0] timer_csr_rvalue;
  logic        timer_int;
  logic [63:0] cnt_value;
  logic [31:0] cnt_id;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state
  logic [31:0] m_tid, m_tcfg, m_tval;
  logic        m_ip;
  logic [63:0] m_cnt;

  csr_timer #(.TIMER_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .csr_we           (csr_we),
    .csr_num          (csr_num),
    .csr_wmask        (csr_wmask),
    .csr_wvalue       (csr_wvalue),
    .timer_csr_hit    (timer_csr_hit),
    .timer_csr_rvalue (timer_csr_rvalue),
    .timer_int        (timer_int),
    .cnt_value        (cnt_value),
    .cnt_id           (cnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [13:0] num);
    case (num)
      A_TID:   return m_tid;
      A_TCFG:  return m_tcfg;
      A_TVAL:  return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_hit(input logic [13:0] num);
    return (num == A_TID) || (num == A_TCFG) || (num == A_TVAL) || (num == A_TICLR);
  endfunction

  // Reference model: apply the timer rules once per rising edge
  always @(posedge clk) begin
    logic [31:0] newcfg, nxt_tval;
    logic        nxt_ip;
    if (reset) begin
      m_tid  = 32'h0;
      m_tcfg = 32'h0;
      m_tval = 32'hFFFF_FFFF;
      m_ip   = 1'b0;
      m_cnt  = 64'h0;
    end else begin
      m_cnt  = m_cnt + 64'd1;
      newcfg = (csr_wmask & csr_wvalue) | (~csr_wmask & m_tcfg);
      nxt_ip = m_ip;
      if (csr_we && csr_num == A_TICLR && csr_wmask[0] && csr_wvalue[0]) nxt_ip = 1'b0;
      if (m_tcfg[0] && m_tval == 32'h0) nxt_ip = 1'b1;
      nxt_tval = m_tval;
      if (csr_we && csr_num == A_TCFG) begin
        if (newcfg[0]) nxt_tval = newcfg & 32'hFFFF_FFFC;
      end else if (m_tcfg[0] && m_tval != 32'hFFFF_FFFF) begin
        if (m_tval == 32'h0 && m_tcfg[1]) nxt_tval = m_tcfg & 32'hFFFF_FFFC;
        else nxt_tval = m_tval - 32'd1;
      end
      if (csr_we && csr_num == A_TID) m_tid = (csr_wmask & csr_wvalue) | (~csr_wmask & m_tid);
      if (csr_we && csr_num == A_TCFG) m_tcfg = newcfg;
      m_tval = nxt_tval;
      m_ip   = nxt_ip;
    end
  end

  // Compare every cycle, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cnt_id", {32'h0, cnt_id}, {32'h0, m_tid});
      chk("timer_int", {63'h0, timer_int}, {63'h0, m_ip});
      chk("cnt_value", cnt_value, m_cnt);
      chk("hit", {63'h0, timer_csr_hit}, {63'h0, m_hit(csr_num)});
      chk("rvalue", {32'h0, timer_csr_rvalue}, {32'h0, m_read(csr_num)});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    step();
    csr_we     = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] v);
    csr_num = num;
    #1;
    v = timer_csr_rvalue;
  endtask

  initial begin
    logic [31:0] v;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    rd(A_TVAL, v);  chk("rst_tval", {32'h0, v}, 64'hFFFF_FFFF);
    rd(A_TCFG, v);  chk("rst_tcfg", {32'h0, v}, 64'h0);
    chk("rst_int", {63'h0, timer_int}, 64'h0);
    chk("rst_cnt", cnt_value, 64'h0);
    reset = 1'b0;

    // One-shot InitVal=5
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0015);
    rd(A_TVAL, v);  chk("oneshot_load", {32'h0, v}, 64'h14);
    step();
    rd(A_TVAL, v);  chk("oneshot_dec", {32'h0, v}, 64'h13);
    repeat (19) step();
    rd(A_TVAL, v);  chk("oneshot_zero", {32'h0, v}, 64'h0);
    chk("oneshot_int_pre", {63'h0, timer_int}, 64'h0);
    step();
    rd(A_TVAL, v);  chk("oneshot_ones", {32'h0, v}, 64'hFFFF_FFFF);
    chk("oneshot_int", {63'h0, timer_int}, 64'h1);
    step();
    rd(A_TVAL, v);  chk("oneshot_hold", {32'h0, v}, 64'hFFFF_FFFF);

    // Periodic InitVal=3
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000F);
    rd(A_TVAL, v);  chk("per_load", {32'h0, v}, 64'hC);
    repeat (12) step();
    rd(A_TVAL, v);  chk("per_zero", {32'h0, v}, 64'h0);
    step();
    rd(A_TVAL, v);  chk("per_reload", {32'h0, v}, 64'hC);
    chk("per_int", {63'h0, timer_int}, 64'h1);

    // TICLR clear, then clear coinciding with expiry
    wr(A_TICLR, 32'h1, 32'h1);
    chk("ticlr_clr", {63'h0, timer_int}, 64'h0);
    rd(A_TICLR, v); chk("ticlr_read", {32'h0, v}, 64'h0);
    repeat (11) step();
    rd(A_TVAL, v);  chk("ticlr_at_zero", {32'h0, v}, 64'h0);
    wr(A_TICLR, 32'h1, 32'h1);
    chk("ticlr_set_wins", {63'h0, timer_int}, 64'h1);

    // Freeze, restart, ignored TVAL write with read-during-write
    repeat (2) step();
    rd(A_TVAL, v);  chk("pre_freeze", {32'h0, v}, 64'hA);
    wr(A_TCFG, 32'h1, 32'h0);
    rd(A_TVAL, v);  chk("freeze", {32'h0, v}, 64'hA);
    step();
    rd(A_TVAL, v);  chk("freeze_hold", {32'h0, v}, 64'hA);
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0009);
    rd(A_TVAL, v);  chk("restart", {32'h0, v}, 64'h8);
    csr_we = 1'b1; csr_num = A_TVAL; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h1234;
    #1;
    chk("rdw_old", {32'h0, timer_csr_rvalue}, 64'h8);
    step();
    csr_we = 1'b0;
    rd(A_TVAL, v);  chk("tval_ro", {32'h0, v}, 64'h7);

    // TID masked writes
    wr(A_TID, 32'h0000_FFFF, 32'hDEAD_BEEF);
    chk("tid_lo", {32'h0, cnt_id}, 64'h0000_BEEF);
    wr(A_TID, 32'hFFFF_0000, 32'h1234_5678);
    chk("tid_hi", {32'h0, cnt_id}, 64'h1234_BEEF);

    // Periodic InitVal=0: TVAL pinned at 0, interrupt keeps re-asserting
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0003);
    step();
    wr(A_TICLR, 32'h1, 32'h1);
    rd(A_TVAL, v);  chk("iv0_tval", {32'h0, v}, 64'h0);
    chk("iv0_int", {63'h0, timer_int}, 64'h1);

    // Reset mid-countdown
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_00F3);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(A_TCFG, v);  chk("mid_rst_tcfg", {32'h0, v}, 64'h0);
    rd(A_TVAL, v);  chk("mid_rst_tval", {32'h0, v}, 64'hFFFF_FFFF);
    chk("mid_rst_int", {63'h0, timer_int}, 64'h0);
    chk("mid_rst_cnt", cnt_value, 64'h0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      int sel;
      reset = ($urandom_range(0, 499) == 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: csr_num = A_TID;
        1: csr_num = A_TCFG;
        2: csr_num = A_TVAL;
        3: csr_num = A_TICLR;
        4: csr_num = 14'h43;
        default: csr_num = 14'($urandom);
      endcase
      csr_we    = ($urandom_range(0, 3) == 0);
      csr_wmask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
      csr_wvalue = (csr_num == A_TCFG) ? 32'($urandom_range(0, 63)) : $urandom;
      step();
    end
    reset  = 1'b0;
    csr_we = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
